// File: rtl/hotkey_mode_ctrl.sv
// Keyboard hotkey decoder: video-mode latches, one-hot test strobes, OSD hide toggle, Ctrl+Alt+Del reset.
// Optional HOTKEY_AUTOREPEAT_EN adds auto-repeat of a held test key every REPEAT_DLY cycles.
module hotkey_mode_ctrl #(
   parameter int unsigned NUM_TESTS  = 6,
   parameter int unsigned PULSE_W    = 4,
   parameter int unsigned RESET_W    = 16,
   parameter int unsigned REPEAT_DLY = 1000000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [7:0]           kbd_status,
   input  logic [7:0]           kbd_data,
   output logic                 mode,
   output logic                 vga,
   output logic [NUM_TESTS-1:0] test_strobe,
   output logic                 test_busy,
   output logic                 hidetextwindow,
   output logic                 master_reset
);

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      RESET
   } state_t;

   localparam logic [7:0]  KEY_MODE0 = 8'h1e;
   localparam logic [7:0]  KEY_MODE1 = 8'h1f;
   localparam logic [7:0]  KEY_MODE2 = 8'h20;
   localparam logic [7:0]  KEY_TEST0 = 8'h21;
   localparam logic [7:0]  KEY_SPACE = 8'h2c;
   localparam logic [7:0]  KEY_DEL   = 8'h4c;
   localparam logic [15:0] PULSE_LD  = 16'(PULSE_W - 1);
   localparam logic [15:0] RESET_LD  = 16'(RESET_W - 1);

   state_t               state;
   state_t               state_nxt;
   logic [7:0]           prev_data;
   logic [15:0]          counter;
   logic [NUM_TESTS-1:0] key_dec;
   logic [NUM_TESTS-1:0] strobe_sel;
   logic                 key_new;
   logic                 ctrl_held;
   logic                 alt_held;
   logic                 cad_hit;
   logic                 rpt_due;
   logic                 test_fire;
   logic                 unused_status;

   assign unused_status = ^{kbd_status[7], kbd_status[5], kbd_status[3], kbd_status[1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev_data <= '0;
      else          prev_data <= kbd_data;
   end

   assign key_new   = (kbd_data != '0) && (kbd_data != prev_data);
   assign ctrl_held = kbd_status[0] | kbd_status[4];
   assign alt_held  = kbd_status[2] | kbd_status[6];
   assign cad_hit   = key_new && (kbd_data == KEY_DEL) && ctrl_held && alt_held;

   always_comb begin
      key_dec = '0;
      for (int unsigned i = 0; i < NUM_TESTS; i++) begin
         if (kbd_data == 8'(KEY_TEST0 + i)) key_dec[i] = 1'b1;
      end
   end

`ifdef HOTKEY_AUTOREPEAT_EN
   localparam logic [23:0] RPT_LAST = 24'(REPEAT_DLY - 1);

   logic [23:0] rpt_cnt;

   // Counts cycles since the last strobe launch or the last code change; saturates rather than wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  rpt_cnt <= '0;
      else if ((kbd_data != prev_data) || test_fire) rpt_cnt <= '0;
      else if (rpt_cnt != '1)                        rpt_cnt <= rpt_cnt + 24'd1;
   end

   assign rpt_due = (kbd_data == prev_data) && (rpt_cnt == RPT_LAST);
`else
   logic unused_repeat_dly;

   assign unused_repeat_dly = ^REPEAT_DLY;
   assign rpt_due           = 1'b0;
`endif

   assign test_fire = (state == IDLE) && (|key_dec) && (key_new || rpt_due);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cad_hit) begin
         state_nxt = RESET;
      end else begin
         case (state)
            IDLE:    if (test_fire) state_nxt = PULSE;
            PULSE:   if (counter == '0) state_nxt = IDLE;
            RESET:   if (counter == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      test_strobe  = (state == PULSE) ? strobe_sel : '0;
      test_busy    = (state != IDLE);
      master_reset = (state == RESET);
   end

   // One counter serves both the strobe width and the reset stretch; it stops at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            counter <= '0;
      else if (cad_hit)        counter <= RESET_LD;
      else if (test_fire)      counter <= PULSE_LD;
      else if (counter != '0)  counter <= counter - 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       strobe_sel <= '0;
      else if (test_fire) strobe_sel <= key_dec;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode <= 1'b1;
         vga  <= 1'b1;
      end else if (key_new) begin
         case (kbd_data)
            KEY_MODE0: begin mode <= 1'b0; vga <= 1'b0; end
            KEY_MODE1: begin mode <= 1'b1; vga <= 1'b0; end
            KEY_MODE2: begin mode <= 1'b1; vga <= 1'b1; end
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                             hidetextwindow <= 1'b0;
      else if (key_new && kbd_data == KEY_SPACE) hidetextwindow <= ~hidetextwindow;
   end

endmodule

// File: tb/tb_hotkey_mode_ctrl.sv
// Bench for hotkey_mode_ctrl: fixed vector table, corner-case sequences, randomized run against a model.
module tb_hotkey_mode_ctrl;
   localparam int NT = 6;
   localparam int PW = 4;
   localparam int RW = 16;
   localparam int RD = 50;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [7:0]    kbd_status = '0;
   logic [7:0]    kbd_data = '0;
   logic          mode, vga, test_busy, hidetextwindow, master_reset;
   logic [NT-1:0] test_strobe;

   always #5 clk = ~clk;

   hotkey_mode_ctrl #(
      .NUM_TESTS (NT),
      .PULSE_W   (PW),
      .RESET_W   (RW),
      .REPEAT_DLY(RD)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .kbd_status    (kbd_status),
      .kbd_data      (kbd_data),
      .mode          (mode),
      .vga           (vga),
      .test_strobe   (test_strobe),
      .test_busy     (test_busy),
      .hidetextwindow(hidetextwindow),
      .master_reset  (master_reset)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: remaining-high-cycle counts per output, edge numbers for auto-repeat timing.
   bit            m_mode, m_vga, m_hide;
   logic [NT-1:0] m_strobe;
   logic [7:0]    m_prev;
   int            m_pulse_left, m_reset_left;
   int            edge_no = 0;
   int            last_fire, last_change;

   typedef struct {
      logic [7:0]    st;
      logic [7:0]    d;
      logic          mode;
      logic          vga;
      logic [NT-1:0] strobe;
      logic          busy;
      logic          hide;
      logic          mrst;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 1; m_vga = 1; m_hide = 0;
      m_strobe = '0; m_prev = '0;
      m_pulse_left = 0; m_reset_left = 0;
      last_change = edge_no;
      last_fire = -1000000;
   endtask

   task automatic model_edge(input logic [7:0] st, input logic [7:0] d);
      bit key_new, cad, idle, is_test, rep;
      int idx;
      edge_no++;
      key_new = (d != 8'h00) && (d != m_prev);
      cad     = key_new && (d == 8'h4c) && (st[0] || st[4]) && (st[2] || st[6]);
      idle    = (m_pulse_left == 0) && (m_reset_left == 0);
      is_test = (d >= 8'h21) && (int'(d) < 'h21 + NT);
      idx     = int'(d) - 'h21;
      rep     = 0;
`ifdef HOTKEY_AUTOREPEAT_EN
      rep = is_test && (d == m_prev) &&
            (edge_no - ((last_fire > last_change) ? last_fire : last_change) == RD);
`endif
      if (m_pulse_left > 0) m_pulse_left--;
      if (m_reset_left > 0) m_reset_left--;
      if (cad) begin
         m_pulse_left = 0;
         m_reset_left = RW;
      end else if (idle && is_test && (key_new || rep)) begin
         m_pulse_left = PW;
         m_strobe = '0;
         m_strobe[idx] = 1'b1;
         last_fire = edge_no;
      end
      if (d != m_prev) last_change = edge_no;
      if (key_new) begin
         case (d)
            8'h1e: begin m_mode = 0; m_vga = 0; end
            8'h1f: begin m_mode = 1; m_vga = 0; end
            8'h20: begin m_mode = 1; m_vga = 1; end
            8'h2c: m_hide = !m_hide;
            default: ;
         endcase
      end
      m_prev = d;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_mode"},   mode, m_mode);
      chk({tag, "_vga"},    vga, m_vga);
      chk({tag, "_hide"},   hidetextwindow, m_hide);
      chk({tag, "_strobe"}, test_strobe, (m_pulse_left > 0) ? int'(m_strobe) : 0);
      chk({tag, "_busy"},   test_busy, int'((m_pulse_left > 0) || (m_reset_left > 0)));
      chk({tag, "_mrst"},   master_reset, int'(m_reset_left > 0));
   endtask

   task automatic drive(input logic [7:0] st, input logic [7:0] d);
      kbd_status = st;
      kbd_data   = d;
      @(posedge clk);
      model_edge(st, d);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_mode"},   mode, 1);
      chk({tag, "_vga"},    vga, 1);
      chk({tag, "_hide"},   hidetextwindow, 0);
      chk({tag, "_strobe"}, test_strobe, 0);
      chk({tag, "_busy"},   test_busy, 0);
      chk({tag, "_mrst"},   master_reset, 0);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      kbd_status = '0;
      kbd_data = '0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   // Asynchronous reset pulse between edges; outputs must drop before any clock edge.
   task automatic async_reset_pulse(input string tag);
      reset_n = 1'b0;
      #1;
      check_reset_values(tag);
      model_reset();
      #1;
      reset_n = 1'b1;
   endtask

   function automatic vec_t mk(input logic [7:0] st, input logic [7:0] d, input logic md,
                               input logic vg, input logic [NT-1:0] sb, input logic by,
                               input logic hd, input logic mr);
      vec_t v;
      v.st = st; v.d = d; v.mode = md; v.vga = vg;
      v.strobe = sb; v.busy = by; v.hide = hd; v.mrst = mr;
      return v;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt, hi, prev_s;
      int rises[$];
      logic [7:0] stat_tbl[8];
      logic [7:0] st, d;
      int len, pick;

      // Fixed vectors: {status, data} -> outputs after the edge.
      tbl.push_back(mk(8'h00, 8'h1e, 0, 0, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h1e, 0, 0, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h1e, 0, 0, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h20, 1, 1, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h1f, 1, 0, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h20, 1, 1, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h23, 1, 1, 6'h04, 1, 0, 0));
      tbl.push_back(mk(8'h00, 8'h23, 1, 1, 6'h04, 1, 0, 0));
      tbl.push_back(mk(8'h00, 8'h23, 1, 1, 6'h04, 1, 0, 0));
      tbl.push_back(mk(8'h00, 8'h23, 1, 1, 6'h04, 1, 0, 0));
      tbl.push_back(mk(8'h00, 8'h23, 1, 1, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h23, 1, 1, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h23, 1, 1, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h2c, 1, 1, 6'h00, 0, 1, 0));
      tbl.push_back(mk(8'h00, 8'h2c, 1, 1, 6'h00, 0, 1, 0));
      tbl.push_back(mk(8'h00, 8'h00, 1, 1, 6'h00, 0, 1, 0));
      tbl.push_back(mk(8'h00, 8'h2c, 1, 1, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h27, 1, 1, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h21, 1, 1, 6'h01, 1, 0, 0));
      tbl.push_back(mk(8'h00, 8'h00, 1, 1, 6'h01, 1, 0, 0));
      tbl.push_back(mk(8'h00, 8'h22, 1, 1, 6'h01, 1, 0, 0));
      tbl.push_back(mk(8'h00, 8'h22, 1, 1, 6'h01, 1, 0, 0));
      tbl.push_back(mk(8'h00, 8'h22, 1, 1, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h00, 1, 1, 6'h00, 0, 0, 0));
      tbl.push_back(mk(8'h00, 8'h22, 1, 1, 6'h02, 1, 0, 0));
      tbl.push_back(mk(8'h05, 8'h4c, 1, 1, 6'h00, 1, 0, 1));
      tbl.push_back(mk(8'h00, 8'h00, 1, 1, 6'h00, 1, 0, 1));

      apply_reset();
      check_reset_values("reset");

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].d);
         chk($sformatf("tbl%0d_mode", i),   mode, tbl[i].mode);
         chk($sformatf("tbl%0d_vga", i),    vga, tbl[i].vga);
         chk($sformatf("tbl%0d_strobe", i), test_strobe, tbl[i].strobe);
         chk($sformatf("tbl%0d_busy", i),   test_busy, tbl[i].busy);
         chk($sformatf("tbl%0d_hide", i),   hidetextwindow, tbl[i].hide);
         chk($sformatf("tbl%0d_mrst", i),   master_reset, tbl[i].mrst);
      end

      // Ctrl+Alt+Del mid-pulse: strobe drops, reset stretched to RW cycles.
      apply_reset();
      drive(8'h00, 8'h21);
      drive(8'h00, 8'h00);
      drive(8'h05, 8'h4c);
      chk("cad_strobe", test_strobe, 0);
      chk("cad_mrst", master_reset, 1);
      cnt = 1;
      for (int i = 0; i < 40; i++) begin
         drive(8'h05, 8'h4c);
         cnt += int'(master_reset);
      end
      chk("cad_len", cnt, RW);

      // Ctrl without Alt: no reset, strobe continues.
      apply_reset();
      drive(8'h00, 8'h21);
      drive(8'h00, 8'h00);
      drive(8'h01, 8'h4c);
      chk("noalt_strobe", test_strobe, 1);
      chk("noalt_mrst", master_reset, 0);

      // Repeated Ctrl+Alt+Del (right-hand modifiers) reloads the stretch.
      apply_reset();
      drive(8'h50, 8'h4c);
      cnt = int'(master_reset);
      for (int i = 0; i < 5; i++) begin
         drive(8'h50, 8'h00);
         cnt += int'(master_reset);
      end
      drive(8'h50, 8'h4c);
      cnt += int'(master_reset);
      for (int i = 0; i < 40; i++) begin
         drive(8'h00, 8'h00);
         cnt += int'(master_reset);
      end
      chk("cad_reload_len", cnt, 6 + RW);

      // Asynchronous reset during the reset stretch.
      apply_reset();
      drive(8'h14, 8'h4c);
      drive(8'h00, 8'h00);
      drive(8'h00, 8'h1e);
      chk("midrst_mrst_before", master_reset, 1);
      async_reset_pulse("midrst");
      kbd_data = 8'h00;
      for (int i = 0; i < 3; i++) begin
         drive(8'h00, 8'h00);
         chk("midrst_after_mrst", master_reset, 0);
         chk("midrst_after_mode", mode, 1);
      end

      // Back-to-back: key seen in the last PULSE cycle is dropped, first IDLE cycle is accepted.
      apply_reset();
      for (int i = 0; i < 4; i++) drive(8'h00, 8'h21);
      chk("b2b_last_hi", test_strobe, 1);
      drive(8'h00, 8'h21);
      chk("b2b_gap", test_strobe, 0);
      drive(8'h00, 8'h22);
      chk("b2b_next", test_strobe, 2);

      // Held test key for 160 cycles.
      apply_reset();
      prev_s = 0;
      hi = 0;
      for (int i = 0; i < 160; i++) begin
         drive(8'h00, 8'h24);
         if (test_strobe[3] && prev_s == 0) rises.push_back(i);
         prev_s = int'(test_strobe[3]);
         hi += int'(test_strobe[3]);
      end
`ifdef HOTKEY_AUTOREPEAT_EN
      chk("rpt_count", rises.size(), 4);
      chk("rpt_high", hi, 4 * PW);
      if (rises.size() == 4) begin
         chk("rpt_first", rises[0], 0);
         for (int k = 1; k < 4; k++) chk($sformatf("rpt_gap%0d", k), rises[k] - rises[k-1], RD);
      end
`else
      chk("hold_count", rises.size(), 1);
      chk("hold_high", hi, PW);
`endif

      // Randomized traffic against the model.
      stat_tbl[0] = 8'h00; stat_tbl[1] = 8'h05; stat_tbl[2] = 8'h50; stat_tbl[3] = 8'h14;
      stat_tbl[4] = 8'h41; stat_tbl[5] = 8'h01; stat_tbl[6] = 8'h44; stat_tbl[7] = 8'h11;
      apply_reset();
      for (int seg = 0; seg < 1500; seg++) begin
         if ($urandom_range(0, 299) == 0) async_reset_pulse("rnd_arst");
         st = ($urandom_range(0, 3) == 0) ? 8'($urandom) : stat_tbl[$urandom_range(0, 7)];
         pick = $urandom_range(0, 15);
         case (pick)
            0, 14:   d = 8'h00;
            1:       d = 8'h1e;
            2:       d = 8'h1f;
            3:       d = 8'h20;
            10:      d = 8'h27;
            11:      d = 8'h2c;
            12, 13:  d = 8'h4c;
            15:      d = 8'($urandom);
            default: d = 8'(8'h21 + (pick - 4));
         endcase
         len = ($urandom_range(0, 15) == 0) ? $urandom_range(40, 120) : $urandom_range(1, 6);
         for (int c = 0; c < len; c++) begin
            drive(st, d);
            check_model("rnd");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
